fetch_stage: RTL and testbench

Instruction-fetch stage of the 16-bit RISC pipeline, directly upstream of the decode stage. Owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register consumed by decode. Applies decode-issued redirects, stalls and flushes. Latches external interrupt requests until decode acknowledges them.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/pc_unit.sv | 39 +++
 rtl/fetch_stage.sv | 97 +++++++++
 tb/tb_fetch_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the 16-bit RISC pipeline
package cpu_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int PC_W_DEF  = 32;

  typedef enum logic [1:0] {
    PC_SEQ   = 2'b00,
    PC_JMP   = 2'b01,
    PC_STACK = 2'b10,
    PC_INT   = 2'b11
  } pc_sel_e;

  typedef enum logic {
    INT_IDLE = 1'b0,
    INT_PEND = 1'b1
  } int_state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter register, next-PC mux and incrementer
module pc_unit
  import cpu_pkg::*;
#(
  parameter int             PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] INT_VECTOR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      i_pc_sel,
  input  logic [PC_W-1:0] i_pc_jmp,
  input  logic [PC_W-1:0] i_pc_stack,
  input  logic            i_hold,
  output logic [PC_W-1:0] o_pc
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;

  // A redirect overrides any freeze or stall; the increment wraps naturally.
  always_comb begin
    w_pc_next = r_pc;
    case (i_pc_sel)
      PC_JMP:   w_pc_next = i_pc_jmp;
      PC_STACK: w_pc_next = i_pc_stack;
      PC_INT:   w_pc_next = INT_VECTOR;
      default:  if (!i_hold) w_pc_next = r_pc + PC_W'(1);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch: PC, IF/ID register and interrupt latch
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int              WIDTH      = WIDTH_DEF,
  parameter int              PC_W       = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [PC_W-1:0] INT_VECTOR = 32'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [WIDTH-1:0] imem_data,
  input  logic [1:0]       pc_sel,
  input  logic [PC_W-1:0]  pc_jmp,
  input  logic [PC_W-1:0]  pc_stack,
  input  logic             fetch_pc_enable,
  input  logic             load_use,
  input  logic             flush_fetch,
  input  logic             interrupt,
  input  logic             ack,
  output logic [WIDTH-1:0] instruction,
  output logic [PC_W-1:0]  pc_out,
  output logic [PC_W-1:0]  pc_plus1,
  output logic             if_valid,
  output logic             int_req
);

  logic [PC_W-1:0]  w_pc;
  logic             w_redirect;
  logic             w_hold;
  logic [WIDTH-1:0] r_instruction;
  logic [PC_W-1:0]  r_pc_out;
  logic             r_if_valid;
  int_state_e       r_int_state;
  int_state_e       w_int_next;

  assign w_redirect = (pc_sel != PC_SEQ);
  assign w_hold     = !fetch_pc_enable || load_use;

  pc_unit #(
    .PC_W       (PC_W),
    .RESET_PC   (RESET_PC),
    .INT_VECTOR (INT_VECTOR)
  ) u_pc_unit (
    .clk        (clk),
    .rst        (rst),
    .i_pc_sel   (pc_sel),
    .i_pc_jmp   (pc_jmp),
    .i_pc_stack (pc_stack),
    .i_hold     (w_hold),
    .o_pc       (w_pc)
  );

  // Redirect squashes even under a hold; a flush under a hold is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instruction <= WIDTH'(NOP_INSTR);
      r_pc_out      <= RESET_PC;
      r_if_valid    <= 1'b0;
    end else if (w_redirect) begin
      r_instruction <= WIDTH'(NOP_INSTR);
      r_pc_out      <= w_pc;
      r_if_valid    <= 1'b0;
    end else if (!w_hold) begin
      r_instruction <= flush_fetch ? WIDTH'(NOP_INSTR) : imem_data;
      r_pc_out      <= w_pc;
      r_if_valid    <= !flush_fetch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_int_state <= INT_IDLE;
    else     r_int_state <= w_int_next;
  end

  // An ack in PEND always wins, so a same-cycle request is not re-latched.
  always_comb begin
    w_int_next = r_int_state;
    case (r_int_state)
      INT_IDLE: if (interrupt) w_int_next = INT_PEND;
      INT_PEND: if (ack)       w_int_next = INT_IDLE;
      default:                 w_int_next = INT_IDLE;
    endcase
  end

  always_comb begin
    int_req = (r_int_state == INT_PEND);
  end

  assign imem_addr   = w_pc;
  assign instruction = r_instruction;
  assign pc_out      = r_pc_out;
  assign pc_plus1    = r_pc_out + PC_W'(1);
  assign if_valid    = r_if_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [15:0] imem_data;
  logic [1:0]  pc_sel;
  logic [31:0] pc_jmp;
  logic [31:0] pc_stack;
  logic        fetch_pc_enable;
  logic        load_use;
  logic        flush_fetch;
  logic        interrupt;
  logic        ack;
  logic [15:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_plus1;
  logic        if_valid;
  logic        int_req;

  int n_checks = 0;
  int n_err    = 0;

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .pc_sel          (pc_sel),
    .pc_jmp          (pc_jmp),
    .pc_stack        (pc_stack),
    .fetch_pc_enable (fetch_pc_enable),
    .load_use        (load_use),
    .flush_fetch     (flush_fetch),
    .interrupt       (interrupt),
    .ack             (ack),
    .instruction     (instruction),
    .pc_out          (pc_out),
    .pc_plus1        (pc_plus1),
    .if_valid        (if_valid),
    .int_req         (int_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mem(input logic [31:0] a);
    if (a == 32'd0)      return 16'h1234;
    else if (a == 32'd1) return 16'h5678;
    else                 return a[15:0] ^ 16'hBEEF;
  endfunction

  assign imem_data = mem(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_addr, input logic [15:0] e_instr,
                         input logic [31:0] e_pcout, input logic e_valid, input logic e_int);
    chk({tag, ".imem_addr"},   imem_addr,   e_addr);
    chk({tag, ".instruction"}, {16'h0, instruction}, {16'h0, e_instr});
    chk({tag, ".pc_out"},      pc_out,      e_pcout);
    chk({tag, ".pc_plus1"},    pc_plus1,    e_pcout + 32'd1);
    chk({tag, ".if_valid"},    {31'h0, if_valid}, {31'h0, e_valid});
    chk({tag, ".int_req"},     {31'h0, int_req},  {31'h0, e_int});
  endtask

  task automatic drive(input logic [1:0] sel, input logic [31:0] jmp, input logic [31:0] stk,
                       input logic en, input logic lu, input logic fl, input logic intr, input logic ak);
    pc_sel = sel; pc_jmp = jmp; pc_stack = stk; fetch_pc_enable = en;
    load_use = lu; flush_fetch = fl; interrupt = intr; ack = ak;
  endtask

  task automatic idle();
    drive(2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] jmp;
    logic [31:0] stk;
    logic        en, lu, fl, intr, ak;
    logic [31:0] e_addr;
    logic [15:0] e_instr;
    logic [31:0] e_pcout;
    logic        e_valid, e_int;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] sel, input logic [31:0] jmp, input logic [31:0] stk,
                              input logic en, input logic lu, input logic fl, input logic intr,
                              input logic ak, input logic [31:0] e_addr, input logic [15:0] e_instr,
                              input logic [31:0] e_pcout, input logic e_valid, input logic e_int);
    vec_t v;
    v.sel = sel; v.jmp = jmp; v.stk = stk; v.en = en; v.lu = lu; v.fl = fl;
    v.intr = intr; v.ak = ak; v.e_addr = e_addr; v.e_instr = e_instr;
    v.e_pcout = e_pcout; v.e_valid = e_valid; v.e_int = e_int;
    return v;
  endfunction

  vec_t vecs[$];

  // Behavioural reference state for the randomized phase.
  logic [31:0] m_pc, m_pcout;
  logic [15:0] m_instr;
  logic        m_valid, m_pend;

  task automatic model_edge();
    logic [31:0] target;
    logic        stalled;
    target  = (pc_sel == 2'b01) ? pc_jmp : (pc_sel == 2'b10) ? pc_stack : 32'h0000_0001;
    stalled = !fetch_pc_enable || load_use;
    if (pc_sel != 2'b00) begin
      m_pcout = m_pc; m_instr = 16'h0000; m_valid = 1'b0; m_pc = target;
    end else if (!stalled) begin
      m_pcout = m_pc;
      m_instr = flush_fetch ? 16'h0000 : mem(m_pc);
      m_valid = !flush_fetch;
      m_pc    = m_pc + 32'd1;
    end
    if (m_pend) m_pend = !ack;
    else        m_pend = interrupt;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #2;
    chk_all("async_reset_at_start", 32'h0, 16'h0, 32'h0, 1'b0, 1'b0);
    do_reset();
    #1;
    chk_all("reset", 32'h0, 16'h0, 32'h0, 1'b0, 1'b0);

    //        sel    jmp        stk        en lu fl in ak   addr       instr     pcout      v  int
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h1,     16'h1234, 32'h0,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h2,     16'h5678, 32'h1,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h3,     16'hBEED, 32'h2,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h4,     16'hBEEC, 32'h3,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h5,     16'hBEEB, 32'h4,     1, 0));
    vecs.push_back(mk(2'b01, 32'h100,   32'h0,     1, 0, 0, 0, 0, 32'h100,   16'h0000, 32'h5,     0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h101,   16'hBFEF, 32'h100,   1, 0));
    vecs.push_back(mk(2'b01, 32'h7,     32'h0,     1, 0, 0, 0, 0, 32'h7,     16'h0000, 32'h101,   0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 1, 0, 0, 0, 32'h7,     16'h0000, 32'h101,   0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 1, 0, 0, 0, 32'h7,     16'h0000, 32'h101,   0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h8,     16'hBEE8, 32'h7,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h9,     16'hBEE7, 32'h8,     1, 0));
    vecs.push_back(mk(2'b10, 32'h0,     32'h40,    1, 1, 0, 0, 0, 32'h40,    16'h0000, 32'h9,     0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 1, 0, 0, 32'h41,    16'h0000, 32'h40,    0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h42,    16'hBEAE, 32'h41,    1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     0, 0, 1, 0, 0, 32'h42,    16'hBEAE, 32'h41,    1, 0));
    vecs.push_back(mk(2'b11, 32'h0,     32'h0,     0, 0, 0, 0, 0, 32'h1,     16'h0000, 32'h42,    0, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h2,     16'h5678, 32'h1,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 1, 0, 32'h3,     16'hBEED, 32'h2,     1, 1));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 1, 0, 0, 0, 32'h3,     16'hBEED, 32'h2,     1, 1));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 1, 0, 0, 0, 32'h3,     16'hBEED, 32'h2,     1, 1));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 1, 0, 0, 0, 32'h3,     16'hBEED, 32'h2,     1, 1));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 1, 32'h4,     16'hBEEC, 32'h3,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 1, 0, 32'h5,     16'hBEEB, 32'h4,     1, 1));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 1, 1, 32'h6,     16'hBEEA, 32'h5,     1, 0));
    vecs.push_back(mk(2'b00, 32'h0,     32'h0,     1, 0, 0, 0, 0, 32'h7,     16'hBEE9, 32'h6,     1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].sel, vecs[i].jmp, vecs[i].stk, vecs[i].en, vecs[i].lu, vecs[i].fl,
            vecs[i].intr, vecs[i].ak);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pcout,
              vecs[i].e_valid, vecs[i].e_int);
    end

    // PC wrap at the top of the address space, with an interrupt left pending.
    drive(2'b01, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); @(negedge clk);
    chk_all("wrap_jump", 32'hFFFF_FFFF, 16'h0000, 32'h7, 1'b0, 1'b1);
    idle();
    @(posedge clk); @(negedge clk);
    chk_all("wrap_seq", 32'h0, 16'h4110, 32'hFFFF_FFFF, 1'b1, 1'b1);
    chk("wrap_pc_plus1_zero", pc_plus1, 32'h0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_all("async_reset_mid", 32'h0, 16'h0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk_all("after_reset_fetch", 32'h1, 16'h1234, 32'h0, 1'b1, 1'b0);

    // Randomized phase against the reference model.
    do_reset();
    m_pc = 32'h0; m_pcout = 32'h0; m_instr = 16'h0; m_valid = 1'b0; m_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [1:0] sel;
      sel = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
      drive(sel,
            ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE + 32'($urandom_range(0, 1)) : $urandom,
            $urandom,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0);
      model_edge();
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("rand%0d", c), m_pc, m_instr, m_pcout, m_valid, m_pend);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
